pulse_gen_multi: RTL and testbench

- Parametrised, synthesizable multi-channel pulse/waveform generator; successor to the fixed, delay-based pulse generators used in the clocked test modules.
- Each channel produces a periodic rectangular pulse from cycle counters, with programmable period, high time and burst count.
- Supports continuous and burst modes.
- Sits beside the clock generator and feeds stimulus/timing signals to downstream sequential blocks.

---
 rtl/pulse_gen_multi.sv | 179 +++++++++++++++++
 tb/tb_pulse_gen_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Multi-channel periodic pulse generator with continuous and burst modes.
// Optional start-phase delay is compiled in when PULSE_GEN_PHASE_EN is defined.
module pulse_gen_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic [WIDTH-1:0]    period_in,
  input  logic [WIDTH-1:0]    high_in,
  input  logic [WIDTH-1:0]    burst_in,
  input  logic                mode_in,
`ifdef PULSE_GEN_PHASE_EN
  input  logic [WIDTH-1:0]    phase_in,
`endif
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DELAY = 2'd2
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] per_s, high_s, burst_s;
    logic             mode_s;
`ifdef PULSE_GEN_PHASE_EN
    logic [WIDTH-1:0] phase_s;
    logic [WIDTH-1:0] dly_q, dly_d;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] per_q, per_d, high_q, high_d, rem_q, rem_d;
    logic             mode_q, mode_d;
    logic             pulse_q, pulse_d, done_q, done_d;
    logic [WIDTH-1:0] p_last;
    logic             wrap, sel;

    // Out-of-range selects never match any channel index, so they fall away here.
    assign sel = load && (ch_sel == SEL_W'(i));

    // NOTE: config registers are reset to a defined default because a start
    // before any load must still produce a legal (period 1, high 0) waveform.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        per_s   <= WIDTH'(1);
        high_s  <= '0;
        burst_s <= WIDTH'(1);
        mode_s  <= 1'b0;
`ifdef PULSE_GEN_PHASE_EN
        phase_s <= '0;
`endif
      end else if (sel) begin
        per_s   <= period_in;
        high_s  <= high_in;
        burst_s <= burst_in;
        mode_s  <= mode_in;
`ifdef PULSE_GEN_PHASE_EN
        phase_s <= phase_in;
`endif
      end
    end

    // period 0 behaves as 1, so the last phase is 0 in both cases.
    assign p_last = (per_q == '0) ? '0 : per_q - WIDTH'(1);
    assign wrap   = (phase_q == p_last);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      per_d   = per_q;
      high_d  = high_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
`ifdef PULSE_GEN_PHASE_EN
      dly_d   = dly_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (start[i] && !stop[i]) begin
            per_d   = per_s;
            high_d  = high_s;
            mode_d  = mode_s;
            rem_d   = burst_s;
            phase_d = '0;
            state_d = S_RUN;
`ifdef PULSE_GEN_PHASE_EN
            if (phase_s != '0) begin
              state_d = S_DELAY;
              dly_d   = phase_s - WIDTH'(1);
            end
`endif
          end
        end
        S_RUN: begin
          if (stop[i]) begin
            state_d = S_IDLE;
          end else if (wrap) begin
            phase_d = '0;
            per_d   = per_s;
            high_d  = high_s;
            mode_d  = mode_s;
            // The burst test uses the mode of the period that just ended.
            if (mode_q) begin
              if (rem_q <= WIDTH'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                rem_d = rem_q - WIDTH'(1);
              end
            end
          end else begin
            phase_d = phase_q + WIDTH'(1);
          end
        end
`ifdef PULSE_GEN_PHASE_EN
        S_DELAY: begin
          if (stop[i]) begin
            state_d = S_IDLE;
          end else if (dly_q == '0) begin
            state_d = S_RUN;
          end else begin
            dly_d = dly_q - WIDTH'(1);
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    // pulse_out is registered from next-state values so phase 0 shows one clock after start.
    assign pulse_d = (state_d == S_RUN) && (phase_d < high_d);

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would make update order depend on statement order and race in simulation.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        phase_q <= '0;
        per_q   <= WIDTH'(1);
        high_q  <= '0;
        mode_q  <= 1'b0;
        rem_q   <= WIDTH'(1);
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
`ifdef PULSE_GEN_PHASE_EN
        dly_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        phase_q <= phase_d;
        per_q   <= per_d;
        high_q  <= high_d;
        mode_q  <= mode_d;
        rem_q   <= rem_d;
        pulse_q <= pulse_d;
        done_q  <= done_d;
`ifdef PULSE_GEN_PHASE_EN
        dly_q   <= dly_d;
`endif
      end
    end

    assign pulse_out[i] = pulse_q;
    assign busy[i]      = (state_q != S_IDLE);
    assign done[i]      = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: waveforms, burst completion, stop, reset,
// edge configurations and (with PULSE_GEN_PHASE_EN) the start delay.
module tb_pulse_gen_multi;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load;
  logic [SW-1:0] ch_sel;
  logic [W-1:0]  period_in, high_in, burst_in;
  logic          mode_in;
`ifdef PULSE_GEN_PHASE_EN
  logic [W-1:0]  phase_in;
`endif
  logic [CH-1:0] start, stop;
  logic [CH-1:0] pulse_out, busy, done;

  int checks = 0;
  int errors = 0;

  pulse_gen_multi #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .ch_sel    (ch_sel),
    .period_in (period_in),
    .high_in   (high_in),
    .burst_in  (burst_in),
    .mode_in   (mode_in),
`ifdef PULSE_GEN_PHASE_EN
    .phase_in  (phase_in),
`endif
    .start     (start),
    .stop      (stop),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int ch, input int per, input int hi, input int bu, input logic mo);
    load      = 1'b1;
    ch_sel    = SW'(ch);
    period_in = W'(per);
    high_in   = W'(hi);
    burst_in  = W'(bu);
    mode_in   = mo;
    tick();
    load = 1'b0;
  endtask

  task automatic go(input logic [CH-1:0] mask);
    start = mask;
    tick();
    start = '0;
  endtask

  initial begin
    logic exp3 [11] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

    reset_n = 1'b0; load = 1'b0; ch_sel = '0; period_in = '0; high_in = '0;
    burst_in = '0; mode_in = 1'b0; start = '0; stop = '0;
`ifdef PULSE_GEN_PHASE_EN
    phase_in = '0;
`endif
    #2;
    check("rst_pulse", pulse_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 reset_n = 1'b1;
    tick();

    // Continuous 4/2; a start while running must not restart the period.
    cfg(0, 4, 2, 1, 1'b0);
    go(4'b0001);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("c42_p%0d", j), pulse_out[0], ((j % 4) < 2) ? 1 : 0);
      check($sformatf("c42_b%0d", j), busy[0], 1);
      if (j == 1) start = 4'b0001;
      tick();
      start = '0;
    end

    // Reconfigure mid-period: current 4/2 period completes, then 8/4.
    tick();
    cfg(0, 8, 4, 1, 1'b0);
    for (int j = 0; j < 11; j++) begin
      check($sformatf("recfg_p%0d", j), pulse_out[0], exp3[j]);
      tick();
    end

    // Stop mid-run.
    stop = 4'b0001;
    tick();
    stop = '0;
    check("stop_pulse", pulse_out[0], 0);
    check("stop_busy", busy[0], 0);
    check("stop_done", done[0], 0);
    tick();
    check("stop_pulse2", pulse_out[0], 0);
    check("stop_done2", done[0], 0);

    // Burst 5/1 x3.
    cfg(1, 5, 1, 3, 1'b1);
    go(4'b0010);
    for (int j = 0; j < 17; j++) begin
      check($sformatf("bst_p%0d", j), pulse_out[1], (j < 15 && (j % 5) == 0) ? 1 : 0);
      check($sformatf("bst_d%0d", j), done[1], (j == 15) ? 1 : 0);
      check($sformatf("bst_b%0d", j), busy[1], (j < 15) ? 1 : 0);
      tick();
    end

    // Edge values: 0/0 constant low, 3/7 constant high.
    cfg(2, 0, 0, 1, 1'b0);
    cfg(3, 3, 7, 1, 1'b0);
    go(4'b1100);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("p0_p%0d", j), pulse_out[2], 0);
      check($sformatf("p0_b%0d", j), busy[2], 1);
      check($sformatf("h7_p%0d", j), pulse_out[3], 1);
      check($sformatf("h7_b%0d", j), busy[3], 1);
      tick();
    end
    stop = 4'b1100;
    tick();
    stop = '0;
    check("edge_stop_busy", busy[3:2], 0);

    // Burst count 0 behaves as 1.
    cfg(3, 3, 1, 0, 1'b1);
    go(4'b1000);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("b0_p%0d", j), pulse_out[3], (j == 0) ? 1 : 0);
      check($sformatf("b0_d%0d", j), done[3], (j == 3) ? 1 : 0);
      check($sformatf("b0_b%0d", j), busy[3], (j < 3) ? 1 : 0);
      tick();
    end

    // start and stop together: stop wins.
    start = 4'b0100;
    stop  = 4'b0100;
    tick();
    start = '0;
    stop  = '0;
    check("ss_busy", busy[2], 0);
    check("ss_pulse", pulse_out[2], 0);
    tick();
    check("ss_busy2", busy[2], 0);

    // Asynchronous reset mid-burst, then defaults (period 1, high 0, continuous).
    cfg(0, 4, 2, 1, 1'b0);
    cfg(1, 5, 1, 3, 1'b1);
    go(4'b0011);
    check("pre_rst_pulse", pulse_out[1:0], 2'b11);
    #3 reset_n = 1'b0;
    #1;
    check("arst_pulse", pulse_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    #2 reset_n = 1'b1;
    tick();
    go(4'b0001);
    check("dflt_busy", busy[0], 1);
    check("dflt_pulse", pulse_out[0], 0);
    tick();
    tick();
    check("dflt_busy2", busy[0], 1);
    check("dflt_pulse2", pulse_out[0], 0);
    check("dflt_done", done[0], 0);
    stop = 4'b0001;
    tick();
    stop = '0;

`ifdef PULSE_GEN_PHASE_EN
    // Start delay of 3: first high 4 clocks after start.
    phase_in = W'(3);
    cfg(2, 4, 2, 1, 1'b0);
    phase_in = '0;
    go(4'b0100);
    for (int j = 0; j < 7; j++) begin
      check($sformatf("dly_p%0d", j), pulse_out[2], (j == 3 || j == 4) ? 1 : 0);
      check($sformatf("dly_b%0d", j), busy[2], 1);
      tick();
    end
    stop = 4'b0100;
    tick();
    stop = '0;
    go(4'b0100);
    check("dly2_busy", busy[2], 1);
    stop = 4'b0100;
    tick();
    stop = '0;
    check("dly_stop_busy", busy[2], 0);
    check("dly_stop_pulse", pulse_out[2], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
